// File: rtl/int_to_fp_normalizer.sv
// Sign-magnitude integer to {sign, exp, frac} float converter, value = 0.f * 2^exp.
// Normalises with one left shift per clock behind valid/ready handshakes on both sides.
module int_to_fp_normalizer #(
  parameter int unsigned MagW  = 11,
  parameter int unsigned ExpW  = 4,
  parameter int unsigned FracW = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [MagW:0]           in_int_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [ExpW+FracW:0]     out_fp_o
);

  typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [MagW-1:0]       mag_q, mag_d;
  logic [ExpW-1:0]       exp_q, exp_d;
  logic [ExpW+FracW:0]   out_fp_q, out_fp_d;
  logic                  out_valid_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero operand still spends one cycle in StNorm so that its
  // result appears one cycle after the accept edge, like a fully normalised operand.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid_i) state_d = StNorm;
      StNorm: if (mag_q == '0 || mag_q[MagW-1]) state_d = StDone;
      StDone: if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_o = (state_q == StIdle);
  end

  assign out_valid_o = out_valid_q;
  assign out_fp_o    = out_fp_q;

  // Datapath next-state
  always_comb begin
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    out_fp_d = out_fp_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          mag_d = in_int_i[MagW-1:0];
          if (in_int_i[MagW-1:0] == '0) begin
            sign_d = 1'b0;  // -0 collapses to +0
            exp_d  = '0;
          end else begin
            sign_d = in_int_i[MagW];
            exp_d  = ExpW'(MagW);
          end
        end
      end
      StNorm: begin
        if (mag_q == '0) begin
          out_fp_d = '0;
        end else if (mag_q[MagW-1]) begin
          out_fp_d = {sign_q, exp_q, mag_q[MagW-1 -: FracW]};
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      out_fp_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      out_fp_q    <= out_fp_d;
      out_valid_q <= (state_d == StDone);
    end
  end

endmodule
